// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit (piso) and receive (sipo)
// paths.
//   FRAME_W    : bits per serial frame (start + 8 data + parity + stop)
//   START_BIT  : frame index of the start bit
//   PARITY_BIT : frame index of the parity bit
//   STOP_BIT   : frame index of the stop bit
//   rx_state_t : receive FSM states
package uart_pkg;

  localparam int FRAME_W    = 11;
  localparam int START_BIT  = 0;
  localparam int PARITY_BIT = 9;
  localparam int STOP_BIT   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input bit.
// The first flop may go metastable; the second gives it a full clock period
// to settle before the value is used.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset; both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronized output (two clocks of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/sipo.sv
// sipo: UART receive deserializer.
// Oversamples the synchronized serial line on baud_tick strobes, validates the
// start bit at its centre, then samples every following bit at its centre and
// shifts it in. On the stop-bit sample the whole frame is presented on frame
// with a one-clock rx_done strobe and a stop-bit error flag.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-low reset
//   baud_tick  : one-clock strobe at OVERSAMPLE x baud rate
//   data_tx    : serial line from the transmitter, idles high
//   frame      : received frame; [0]=start, [8:1]=data LSB first,
//                [9]=parity, [10]=stop. Holds between frames.
//   rx_active  : high from start-bit detection until the stop-bit sample
//   rx_done    : one-clock pulse, frame (and stop_error) just updated
//   stop_error : stop bit was sampled low; updated with rx_done, then held
//
// Handshake: rx_done is a pure valid strobe with no ready; the consumer must
// capture frame on the clock where rx_done is high or rely on frame holding
// its value until the next rx_done.
module sipo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               baud_tick,
  input  logic               data_tx,
  output logic [FRAME_W-1:0] frame,
  output logic               rx_active,
  output logic               rx_done,
  output logic               stop_error
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(FRAME_W);

  // Tick counts at which a sample is taken: half a bit after the start edge
  // (start-bit centre), then a full bit period between successive centres.
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

  // Synchronized line; idles high so reset does not look like a start bit.
  logic line_s;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (data_tx),
    .q   (line_s)
  );

  // Registered state and its next-value counterparts.
  rx_state_t              state,      state_n;
  logic [TICK_W-1:0]      tick_cnt,   tick_cnt_n;
  logic [BIT_W-1:0]       bit_cnt,    bit_cnt_n;
  // Holds start, data and parity bits (everything but the stop bit), which
  // arrives last and is merged directly into frame on completion.
  logic [FRAME_W-2:0]     shreg,      shreg_n;
  logic [FRAME_W-1:0]     frame_q,    frame_n;
  logic                   active_q,   active_n;
  logic                   done_q,     done_n;
  logic                   err_q,      err_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      frame_q  <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      frame_q  <= frame_n;
      active_q <= active_n;
      done_q   <= done_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    frame_n    = frame_q;
    active_n   = active_q;
    err_n      = err_q;
    // rx_done is the only thing that changes without a tick: it self-clears.
    done_n     = 1'b0;

    if (baud_tick) begin
      unique case (state)
        IDLE: begin
          if (!line_s) begin
            state_n    = START;
            tick_cnt_n = '0;
            active_n   = 1'b1;
          end
        end

        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt_n = '0;
            if (!line_s) begin
              // Still low at the start-bit centre: a real start bit.
              shreg_n   = {line_s, shreg[FRAME_W-2:1]};
              bit_cnt_n = BIT_W'(START_BIT + 1);
              state_n   = DATA;
            end else begin
              // Line went back high: a glitch. Frame outputs are untouched.
              state_n  = IDLE;
              active_n = 1'b0;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end

        DATA: begin
          if (tick_cnt == FULL_LAST) begin
            shreg_n    = {line_s, shreg[FRAME_W-2:1]};
            tick_cnt_n = '0;
            bit_cnt_n  = bit_cnt + 1'b1;
            // The parity bit is the last one shifted; the stop bit follows.
            if (bit_cnt == BIT_W'(PARITY_BIT)) begin
              state_n = STOP;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end

        STOP: begin
          if (tick_cnt == FULL_LAST) begin
            // Return to IDLE mid-stop-bit so a start bit that follows the
            // stop bit immediately is caught on its first low tick.
            frame_n    = {line_s, shreg};
            err_n      = ~line_s;
            done_n     = 1'b1;
            active_n   = 1'b0;
            tick_cnt_n = '0;
            bit_cnt_n  = '0;
            state_n    = IDLE;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end

        default: begin
          state_n    = IDLE;
          tick_cnt_n = '0;
          bit_cnt_n  = '0;
          active_n   = 1'b0;
        end
      endcase
    end
  end

  assign frame      = frame_q;
  assign rx_active  = active_q;
  assign rx_done    = done_q;
  assign stop_error = err_q;

endmodule : sipo

// File: tb/tb_sipo.sv
// tb_sipo: randomized, scoreboard-checked bench for the UART receive
// deserializer. The driver serializes frames onto data_tx and pushes the
// frame the receiver should report; a monitor pops and compares on rx_done.
module tb_sipo;

  localparam int OS = 16;
  localparam int FW = 11;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          baud_tick = 1'b0;
  logic          data_tx = 1'b1;
  logic [FW-1:0] frame;
  logic          rx_active;
  logic          rx_done;
  logic          stop_error;

  always #5 clk = ~clk;

  sipo #(
    .OVERSAMPLE (OS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .data_tx    (data_tx),
    .frame      (frame),
    .rx_active  (rx_active),
    .rx_done    (rx_done),
    .stop_error (stop_error)
  );

  // baud_tick: one pulse every tick_div clocks, driven on the falling edge.
  int tick_div = 1;
  int tick_ph  = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (tick_ph >= tick_div - 1) begin
        baud_tick = 1'b1;
        tick_ph   = 0;
      end else begin
        baud_tick = 1'b0;
        tick_ph   = tick_ph + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Entry = {expected stop_error, expected frame}.
  logic [FW:0] exp_q[$];
  int tests_run  = 0;
  int tests_fail = 0;
  int done_seen  = 0;
  int pushed     = 0;
  bit active_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (act !== exp) begin
      tests_fail = tests_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the receiver reports exactly the bits that were put on
  // the line; the error flag is the inverse of the stop bit.
  function automatic logic [FW:0] model(input logic [FW-1:0] bits);
    return {~bits[FW-1], bits};
  endfunction

  function automatic logic [FW-1:0] make_frame(input logic [7:0] data,
                                               input logic par,
                                               input logic stop);
    return {stop, par, data, 1'b0};
  endfunction

  // Monitor: pops an expectation on each rx_done.
  initial begin
    logic [FW:0] e;
    forever begin
      @(negedge clk);
      if (rx_active) active_seen = 1'b1;
      if (rx_done) begin
        done_seen = done_seen + 1;
        if (exp_q.size() == 0) begin
          check("unexpected_rx_done", {31'd0, rx_done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("frame", {21'd0, frame}, {21'd0, e[FW-1:0]});
          check("stop_error", {31'd0, stop_error}, {31'd0, e[FW]});
          check("rx_active_at_done", {31'd0, rx_active}, 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_bits(input int n);
    data_tx = 1'b1;
    repeat (n * OS * tick_div) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame"}, {21'd0, frame}, 32'd0);
    check({tag, "_rx_active"}, {31'd0, rx_active}, 32'd0);
    check({tag, "_rx_done"}, {31'd0, rx_done}, 32'd0);
    check({tag, "_stop_error"}, {31'd0, stop_error}, 32'd0);
  endtask

  // Serialize one frame LSB first. abort_bit >= 0 asserts reset half way
  // through that bit instead of completing the frame.
  task automatic send_frame(input logic [FW-1:0] bits, input int abort_bit);
    int period;
    period = OS * tick_div;
    if (abort_bit < 0) begin
      exp_q.push_back(model(bits));
      pushed = pushed + 1;
    end
    for (int i = 0; i < FW; i++) begin
      data_tx = bits[i];
      if (i == abort_bit) begin
        repeat (period / 2) @(negedge clk);
        check("rx_active_mid_frame", {31'd0, rx_active}, 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        data_tx = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("held_reset");
        rst = 1'b1;
        return;
      end
      repeat (period) @(negedge clk);
    end
    data_tx = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n = n + 1;
    end
    check({tag, "_drain"}, exp_q.size(), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    tests_run  = tests_run + 1;
    tests_fail = tests_fail + 1;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending",
             exp_q.size());
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    logic [FW-1:0] f;

    // 1: reset held while the line toggles
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      repeat (7) begin
        @(negedge clk);
        data_tx = ~data_tx;
      end
      check_reset_outputs("reset_hold");
    end
    data_tx = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    idle_bits(2);

    // 2: single good frame 0x54A
    base = done_seen;
    send_frame(11'h54A, -1);
    idle_bits(2);
    drain("single");
    check("single_done_count", done_seen - base, 32'd1);
    check("single_rx_active_idle", {31'd0, rx_active}, 32'd0);

    // 3: start-bit glitch, 4 clocks low
    base = done_seen;
    active_seen = 1'b0;
    data_tx = 1'b0;
    repeat (4) @(negedge clk);
    data_tx = 1'b1;
    idle_bits(3);
    check("glitch_rx_active_seen", {31'd0, active_seen}, 32'd1);
    check("glitch_rx_active_idle", {31'd0, rx_active}, 32'd0);
    check("glitch_no_done", done_seen - base, 32'd0);
    check("glitch_frame_kept", {21'd0, frame}, 32'h54A);

    // 4: stop-bit error, then a good frame clears it
    send_frame(11'h14A, -1);
    idle_bits(2);
    drain("stop_err");
    check("stop_error_held", {31'd0, stop_error}, 32'd1);
    send_frame(11'h54A, -1);
    idle_bits(2);
    drain("stop_err_clear");
    check("stop_error_cleared", {31'd0, stop_error}, 32'd0);

    // 5: reset during data bit 4 (frame index 5), then a good frame
    base = done_seen;
    send_frame(11'h54A, 5);
    idle_bits(2);
    check("abort_no_done", done_seen - base, 32'd0);
    send_frame(11'h54A, -1);
    idle_bits(2);
    drain("after_abort");

    // 6: back-to-back frames, tick every clock and every 4th clock
    for (int d = 1; d <= 4; d += 3) begin
      tick_div = d;
      idle_bits(1);
      base = done_seen;
      send_frame(11'h54A, -1);
      send_frame(11'h7FE, -1);
      idle_bits(2);
      drain("back_to_back");
      check("b2b_done_count", done_seen - base, 32'd2);
    end

    // Randomized frames with random tick spacing and occasional bad stop bit
    for (int k = 0; k < 12; k++) begin
      tick_div = $urandom_range(1, 3);
      idle_bits(1);
      f = make_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0));
      send_frame(f, -1);
      idle_bits(2);
    end
    drain("random");

    check("total_done_count", done_seen, pushed);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule : tb_sipo
